// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response types shared by crossbar ports and pipeline cuts.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_cut_payload_t;

endpackage

// File: rtl/obi_slave_cut_fifo.sv
// obi_slave_cut_fifo: 2-entry in-order FIFO of an arbitrary payload type with full/empty flags.
module obi_slave_cut_fifo #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    T           mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] cnt_q, cnt_d;

    assign cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    assign full_o  = cnt_q == 2'd2;
    assign empty_o = cnt_q == 2'd0;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= !rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/obi_slave_cut.sv
// obi_slave_cut: OBI pipeline cut with 2-entry request buffer and outstanding-transaction limit.
// Define OBI_SLAVE_CUT_RESP_REG_EN to also register the response path (rvalid/rdata).
module obi_slave_cut
    import obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  slave_req_i,
    output obi_resp_t slave_resp_o,
    output obi_req_t  master_req_o,
    input  obi_resp_t master_resp_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    obi_cut_payload_t push_data, head;
    logic             full, empty, push, pop, gnt, ready_q, rsp_valid, dec;
    logic [31:0]      rsp_data;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;

    // ready_q keeps gnt low while in reset and rises on the first edge after release
    assign gnt       = ready_q && !full && (out_cnt_q < CW'(MAX_OUTSTANDING));
    assign push      = slave_req_i.req && gnt;
    assign pop       = !empty && master_resp_i.gnt;
    assign push_data = '{we: slave_req_i.we, be: slave_req_i.be,
                         addr: slave_req_i.addr, wdata: slave_req_i.wdata};

    obi_slave_cut_fifo #(.T(obi_cut_payload_t)) i_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign master_req_o = '{req: !empty, we: head.we, be: head.be,
                            addr: head.addr, wdata: head.wdata};

`ifdef OBI_SLAVE_CUT_RESP_REG_EN
    logic        rvalid_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= master_resp_i.rvalid;
            if (master_resp_i.rvalid) rdata_q <= master_resp_i.rdata;
        end
    end

    assign rsp_valid = rvalid_q;
    assign rsp_data  = rdata_q;
`else
    assign rsp_valid = master_resp_i.rvalid;
    assign rsp_data  = master_resp_i.rdata;
`endif

    assign slave_resp_o = '{gnt: gnt, rvalid: rsp_valid, rdata: rsp_data};

    // a stray response at zero outstanding is not counted
    assign dec       = rsp_valid && (out_cnt_q != '0);
    assign out_cnt_d = out_cnt_q + CW'(push) - CW'(dec);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q   <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            ready_q   <= 1'b1;
            out_cnt_q <= out_cnt_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(master_resp_i.rvalid && out_cnt_q == '0));

endmodule

// File: tb/tb_obi_slave_cut.sv
// tb_obi_slave_cut: table-driven and directed checks of obi_slave_cut (MAX_OUTSTANDING 4 and 2).
module tb_obi_slave_cut;
    import obi_pkg::*;

`ifdef OBI_SLAVE_CUT_RESP_REG_EN
    localparam bit CUT = 1'b1;
`else
    localparam bit CUT = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int NV = 28;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mg;
        logic        mrv;
        logic [31:0] mrd;
        logic        e_gnt;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    obi_req_t  s_req, m_req, req2, mreq2;
    obi_resp_t s_resp, m_resp, resp2, mresp2;
    int        n_chk = 0;
    int        n_fail = 0;
    vec_t      tv [NV];
    logic      prev_mrv;
    logic [31:0] prev_mrd;

    always #5 clk = ~clk;

    obi_slave_cut #(.MAX_OUTSTANDING(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .slave_req_i(s_req), .slave_resp_o(s_resp),
        .master_req_o(m_req), .master_resp_i(m_resp)
    );

    obi_slave_cut #(.MAX_OUTSTANDING(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .slave_req_i(req2), .slave_resp_o(resp2),
        .master_req_o(mreq2), .master_resp_i(mresp2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_req  = '0;
        m_resp = '0;
        req2   = '0;
        mresp2 = '0;
        tv[0]  = '{H, H, 4'hF, 32'h2000_0010, 32'hDEAD_BEEF, H, L, '0, H, L, '0, '0};
        tv[1]  = '{L, L, 4'h0, '0, '0, H, L, '0, H, H, 32'h2000_0010, 32'hDEAD_BEEF};
        tv[2]  = '{L, L, 4'h0, '0, '0, H, H, '0, H, L, '0, '0};
        tv[3]  = '{L, L, 4'h0, '0, '0, H, L, '0, H, L, '0, '0};
        tv[4]  = '{H, L, 4'hF, 32'h0, '0, H, L, '0, H, L, '0, '0};
        tv[5]  = '{H, L, 4'hF, 32'h4, '0, H, L, '0, H, H, 32'h0, '0};
        tv[6]  = '{H, L, 4'hF, 32'h8, '0, H, H, 32'h1111_0000, H, H, 32'h4, '0};
        tv[7]  = '{L, L, 4'h0, '0, '0, H, H, 32'h2222_0004, H, H, 32'h8, '0};
        tv[8]  = '{L, L, 4'h0, '0, '0, H, H, 32'h3333_0008, H, L, '0, '0};
        tv[9]  = '{L, L, 4'h0, '0, '0, H, L, '0, H, L, '0, '0};
        tv[10] = '{L, L, 4'h0, '0, '0, H, L, '0, H, L, '0, '0};
        tv[11] = '{H, H, 4'h3, 32'h100, 32'hA5A5_0001, L, L, '0, H, L, '0, '0};
        tv[12] = '{H, H, 4'hC, 32'h104, 32'hA5A5_0002, L, L, '0, H, H, 32'h100, 32'hA5A5_0001};
        tv[13] = '{H, H, 4'hF, 32'h108, 32'hA5A5_0003, L, L, '0, L, H, 32'h100, 32'hA5A5_0001};
        tv[14] = '{H, H, 4'hF, 32'h108, 32'hA5A5_0003, L, L, '0, L, H, 32'h100, 32'hA5A5_0001};
        tv[15] = '{H, H, 4'hF, 32'h108, 32'hA5A5_0003, L, L, '0, L, H, 32'h100, 32'hA5A5_0001};
        tv[16] = '{H, H, 4'hF, 32'h108, 32'hA5A5_0003, H, L, '0, L, H, 32'h100, 32'hA5A5_0001};
        tv[17] = '{H, H, 4'hF, 32'h108, 32'hA5A5_0003, H, L, '0, H, H, 32'h104, 32'hA5A5_0002};
        tv[18] = '{L, L, 4'h0, '0, '0, H, H, '0, H, H, 32'h108, 32'hA5A5_0003};
        tv[19] = '{L, L, 4'h0, '0, '0, H, H, '0, H, L, '0, '0};
        tv[20] = '{L, L, 4'h0, '0, '0, H, H, '0, H, L, '0, '0};
        tv[21] = '{L, L, 4'h0, '0, '0, H, L, '0, H, L, '0, '0};
        tv[22] = '{H, L, 4'hF, 32'h40, '0, H, L, '0, H, L, '0, '0};
        tv[23] = '{L, L, 4'h0, '0, '0, H, L, '0, H, H, 32'h40, '0};
        tv[24] = '{H, L, 4'hF, 32'h44, '0, H, H, 32'h4040, H, L, '0, '0};
        tv[25] = '{L, L, 4'h0, '0, '0, L, L, '0, H, H, 32'h44, '0};
        tv[26] = '{H, L, 4'hF, 32'h48, '0, L, L, '0, H, H, 32'h44, '0};
        tv[27] = '{L, L, 4'h0, '0, '0, L, L, '0, L, H, 32'h44, '0};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sresp4", 32'(s_resp != '0), 32'(0));
        chk("rst_mreq4", 32'(m_req != '0), 32'(0));
        chk("rst_gnt2", 32'(resp2.gnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_gnt", 32'(s_resp.gnt), 32'(1));
        chk("post_rst_mreq", 32'(m_req.req), 32'(0));

        // table: single write, back-to-back reads, stalled peripheral, buffered requests
        prev_mrv = 1'b0;
        prev_mrd = '0;
        for (int i = 0; i < NV; i++) begin
            s_req  = '{req: tv[i].req, we: tv[i].we, be: tv[i].be, addr: tv[i].addr, wdata: tv[i].wdata};
            m_resp = '{gnt: tv[i].mg, rvalid: tv[i].mrv, rdata: tv[i].mrd};
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(s_resp.gnt), 32'(tv[i].e_gnt));
            chk($sformatf("v%0d_mreq", i), 32'(m_req.req), 32'(tv[i].e_mreq));
            if (tv[i].e_mreq) begin
                chk($sformatf("v%0d_maddr", i), m_req.addr, tv[i].e_addr);
                chk($sformatf("v%0d_mwdata", i), m_req.wdata, tv[i].e_wdata);
            end
            chk($sformatf("v%0d_rvalid", i), 32'(s_resp.rvalid), 32'(CUT ? prev_mrv : tv[i].mrv));
            if (CUT ? prev_mrv : tv[i].mrv)
                chk($sformatf("v%0d_rdata", i), s_resp.rdata, CUT ? prev_mrd : tv[i].mrd);
            if (i == 1) begin
                chk("v1_mwe", 32'(m_req.we), 32'(1));
                chk("v1_mbe", 32'(m_req.be), 32'hF);
            end
            if (i == 13) chk("v13_mbe", 32'(m_req.be), 32'h3);
            prev_mrv = tv[i].mrv;
            if (tv[i].mrv) prev_mrd = tv[i].mrd;
            cyc();
        end

        // reset with two buffered requests
        s_req  = '0;
        m_resp = '0;
        #1;
        chk("pre_rst_mreq", 32'(m_req.req), 32'(1));
        chk("pre_rst_maddr", m_req.addr, 32'h44);
        rst_n = 1'b0;
        #1;
        chk("midrst_sresp", 32'(s_resp != '0), 32'(0));
        chk("midrst_mreq", 32'(m_req != '0), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rerst_gnt", 32'(s_resp.gnt), 32'(1));
        chk("rerst_mreq", 32'(m_req.req), 32'(0));
        cyc();
        chk("rerst_mreq2", 32'(m_req.req), 32'(0));

        // outstanding limit with MAX_OUTSTANDING=2, peripheral withholds rvalid
        req2   = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h10, wdata: '0};
        mresp2 = '{gnt: 1'b1, rvalid: 1'b0, rdata: '0};
        #1;
        chk("lim_gnt0", 32'(resp2.gnt), 32'(1));
        cyc();
        req2.addr = 32'h14;
        #1;
        chk("lim_gnt1", 32'(resp2.gnt), 32'(1));
        chk("lim_maddr1", mreq2.addr, 32'h10);
        cyc();
        req2.addr = 32'h18;
        #1;
        chk("lim_gnt2", 32'(resp2.gnt), 32'(0));
        chk("lim_maddr2", mreq2.addr, 32'h14);
        cyc();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("lim_hold%0d", k), 32'(resp2.gnt), 32'(0));
            cyc();
        end
        mresp2.rvalid = 1'b1;
        mresp2.rdata  = 32'hAAAA_0010;
        #1;
        chk("lim_rv_gnt", 32'(resp2.gnt), 32'(0));
        chk("lim_rv_up", 32'(resp2.rvalid), 32'(!CUT));
        cyc();
        mresp2.rvalid = 1'b0;
        if (CUT) begin
            #1;
            chk("lim_cut_gnt", 32'(resp2.gnt), 32'(0));
            chk("lim_cut_rdata", resp2.rdata, 32'hAAAA_0010);
            cyc();
        end
        #1;
        chk("lim_gnt_rise", 32'(resp2.gnt), 32'(1));
        cyc();
        req2.req = 1'b0;
        #1;
        chk("lim_full_again", 32'(resp2.gnt), 32'(0));
        chk("lim_maddr18", mreq2.addr, 32'h18);
        cyc();

        // simultaneous upstream accept and rvalid at out_cnt=1
        mresp2.rvalid = 1'b1;
        mresp2.rdata  = 32'hBBBB_0014;
        #1;
        chk("sim_rv14", 32'(resp2.rvalid), 32'(!CUT));
        cyc();
        mresp2.rdata = 32'hCCCC_0018;
        if (!CUT) req2 = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h1C, wdata: '0};
        #1;
        chk("sim_gnt_a", 32'(resp2.gnt), 32'(!CUT));
        cyc();
        if (CUT) begin
            mresp2.rvalid = 1'b0;
            req2 = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h1C, wdata: '0};
            #1;
            chk("sim_cut_gnt", 32'(resp2.gnt), 32'(1));
            chk("sim_cut_rdata", resp2.rdata, 32'hCCCC_0018);
            cyc();
        end
        req2.req      = 1'b0;
        mresp2.rvalid = 1'b0;
        #1;
        chk("sim_cnt_kept", 32'(resp2.gnt), 32'(1));
        chk("sim_mreq", 32'(mreq2.req), 32'(1));
        chk("sim_maddr", mreq2.addr, 32'h1C);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
